cache_axi_refill: RTL

- Miss-service engine that sits directly downstream of the cache's miss/write-back outputs and directly upstream of its refill inputs.
- On a cache miss it optionally writes the victim line back over an AXI write burst, then fetches the missing line over an AXI read burst.
- It assembles the fetched data into a full cacheline, presents it on cacheline_new and pulses refresh for one cycle so the cache installs it.

---
 rtl/cache_axi_refill.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cache_axi_refill.sv
// Miss-service engine: optional victim write-back over an AXI write burst, then a line
// refill over an AXI read burst, assembled into cacheline_new and installed with refresh.
module cache_axi_refill #(
    parameter int CACHELINE_WD = 512
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    miss,
    input  logic [31:0]             raddr,
    input  logic                    write_back,
    input  logic [31:0]             waddr,
    input  logic [CACHELINE_WD-1:0] cacheline_old,
    output logic                    refresh,
    output logic [CACHELINE_WD-1:0] cacheline_new,
    output logic                    arvalid,
    input  logic                    arready,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    input  logic                    rvalid,
    output logic                    rready,
    input  logic [31:0]             rdata,
    input  logic                    rlast,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic                    wvalid,
    input  logic                    wready,
    output logic [31:0]             wdata,
    output logic                    wlast,
    input  logic                    bvalid,
    output logic                    bready
);
    // state  | meaning
    // IDLE   | waiting for miss; captures addresses and victim line
    // WB_AW  | write-back address phase
    // WB_W   | write-back data beats from line_buf
    // WB_B   | waiting for write response
    // RD_AR  | refill address phase
    // RD_R   | refill data beats into cacheline_new
    // REFILL | refresh pulse, line ready for install
    // DONE   | one guard cycle so the held miss cannot retrigger

    localparam int BEATS     = CACHELINE_WD / 32;
    localparam int OFFSET_WD = $clog2(CACHELINE_WD / 8);
    localparam int BEAT_WD   = $clog2(BEATS + 1);
    localparam logic [31:0] ALIGN_MASK = ~((32'd1 << OFFSET_WD) - 32'd1);

    typedef enum logic [2:0] {
        IDLE, WB_AW, WB_W, WB_B, RD_AR, RD_R, REFILL, DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [31:0]             raddr_q, raddr_d;
    logic [31:0]             waddr_q, waddr_d;
    logic [CACHELINE_WD-1:0] line_buf_q, line_buf_d;
    logic [CACHELINE_WD-1:0] cacheline_new_q, cacheline_new_d;
    logic [BEAT_WD-1:0]      beat_q, beat_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= IDLE;
            raddr_q         <= '0;
            waddr_q         <= '0;
            line_buf_q      <= '0;
            cacheline_new_q <= '0;
            beat_q          <= '0;
        end else begin
            state_q         <= state_d;
            raddr_q         <= raddr_d;
            waddr_q         <= waddr_d;
            line_buf_q      <= line_buf_d;
            cacheline_new_q <= cacheline_new_d;
            beat_q          <= beat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (miss) state_d = write_back ? WB_AW : RD_AR;
            WB_AW:   if (awready) state_d = WB_W;
            WB_W:    if (wready && beat_q == BEAT_WD'(BEATS - 1)) state_d = WB_B;
            WB_B:    if (bvalid) state_d = RD_AR;
            RD_AR:   if (arready) state_d = RD_R;
            RD_R:    if (rvalid && rlast) state_d = REFILL;
            REFILL:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        raddr_d         = raddr_q;
        waddr_d         = waddr_q;
        line_buf_d      = line_buf_q;
        cacheline_new_d = cacheline_new_q;
        beat_d          = beat_q;
        case (state_q)
            IDLE: begin
                if (miss) begin
                    raddr_d    = raddr;
                    waddr_d    = waddr;
                    line_buf_d = cacheline_old;
                end
            end
            WB_AW: if (awready) beat_d = '0;
            WB_W:  if (wready) beat_d = beat_q + 1'b1;
            RD_AR: if (arready) beat_d = '0;
            RD_R: begin
                // beats past the end of the line are dropped and the counter parks at BEATS
                if (rvalid) begin
                    for (int i = 0; i < BEATS; i++) begin
                        if (beat_q == BEAT_WD'(i)) cacheline_new_d[i*32 +: 32] = rdata;
                    end
                    if (beat_q != BEAT_WD'(BEATS)) beat_d = beat_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        awvalid       = (state_q == WB_AW);
        wvalid        = (state_q == WB_W);
        bready        = (state_q == WB_B);
        arvalid       = (state_q == RD_AR);
        rready        = (state_q == RD_R);
        refresh       = (state_q == REFILL);
        wlast         = wvalid && (beat_q == BEAT_WD'(BEATS - 1));
        araddr        = raddr_q & ALIGN_MASK;
        awaddr        = waddr_q & ALIGN_MASK;
        arlen         = arvalid ? 8'(BEATS - 1) : 8'd0;
        awlen         = awvalid ? 8'(BEATS - 1) : 8'd0;
        cacheline_new = cacheline_new_q;
        wdata         = '0;
        for (int i = 0; i < BEATS; i++) begin
            if (beat_q == BEAT_WD'(i)) wdata = line_buf_q[i*32 +: 32];
        end
    end

endmodule
